// File: rtl/fifo_scsi_reader.sv
// Memory-to-SCSI byte reader: unpacks FIFO longwords into bytes and runs the
// DACK_/WE_ handshake with the SCSI chip, one byte per six-SCLK sequence.
`timescale 1ns/1ps

module fifo_scsi_reader (
    input  logic        SCLK,
    input  logic        RST_FIFO_,
    input  logic [31:0] OD,
    input  logic        FIFOEMPTY,
    input  logic        DIRECTION,
    input  logic        LOAD_BO,
    input  logic [1:0]  START_BO,
    input  logic        DREQ_,
    output logic        DACK_,
    output logic        WE_,
    output logic [7:0]  PD,
    output logic        PD_OE,
    output logic        INCNO,
    output logic [1:0]  BO,
    output logic        BUSY
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE1,
        ST_STROBE2,
        ST_HOLD,
        ST_ADVANCE
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] bo_q, bo_d;
    logic [7:0] pd_q, pd_d;

    // Lane order mirrors the FIFO write side: BO=3 is the least significant byte.
    function automatic logic [7:0] lane_sel(input logic [31:0] od, input logic [1:0] bo);
        logic [7:0] b;
        case (bo)
            2'd3:    b = od[7:0];
            2'd2:    b = od[15:8];
            2'd1:    b = od[23:16];
            default: b = od[31:24];
        endcase
        return b;
    endfunction

    always_ff @(posedge SCLK or negedge RST_FIFO_) begin
        if (!RST_FIFO_) begin
            state_q <= ST_IDLE;
            bo_q    <= 2'd3;
            pd_q    <= 8'h00;
        end else begin
            state_q <= state_d;
            bo_q    <= bo_d;
            pd_q    <= pd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bo_d    = bo_q;
        pd_d    = pd_q;
        DACK_   = 1'b1;
        WE_     = 1'b1;
        PD_OE   = 1'b0;
        INCNO   = 1'b0;
        BUSY    = 1'b1;

        case (state_q)
            ST_IDLE: begin
                BUSY = 1'b0;
                // A pointer load wins; a pending request simply starts one cycle later.
                if (LOAD_BO) begin
                    bo_d = START_BO;
                end else if (DIRECTION && !DREQ_ && !FIFOEMPTY) begin
                    state_d = ST_SETUP;
                    pd_d    = lane_sel(OD, bo_q);
                end
            end
            ST_SETUP: begin
                DACK_   = 1'b0;
                PD_OE   = 1'b1;
                state_d = ST_STROBE1;
            end
            ST_STROBE1: begin
                DACK_   = 1'b0;
                PD_OE   = 1'b1;
                WE_     = 1'b0;
                state_d = ST_STROBE2;
            end
            ST_STROBE2: begin
                DACK_   = 1'b0;
                PD_OE   = 1'b1;
                WE_     = 1'b0;
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                DACK_   = 1'b0;
                PD_OE   = 1'b1;
                state_d = ST_ADVANCE;
            end
            ST_ADVANCE: begin
                // Last byte of the longword consumed: pop the FIFO; BO wraps 0 -> 3.
                INCNO   = (bo_q == 2'd0);
                bo_d    = bo_q - 2'd1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign PD = pd_q;
    assign BO = bo_q;

endmodule

// File: tb/tb_fifo_scsi_reader.sv
// Self-checking bench for fifo_scsi_reader: byte scoreboard popped at each WE_
// falling edge, a transaction table, and hand-written reset/abort sequences.
`timescale 1ns/1ps

module tb_fifo_scsi_reader;

    logic        SCLK;
    logic        RST_FIFO_;
    logic [31:0] OD;
    logic        FIFOEMPTY;
    logic        DIRECTION;
    logic        LOAD_BO;
    logic [1:0]  START_BO;
    logic        DREQ_;
    logic        DACK_;
    logic        WE_;
    logic [7:0]  PD;
    logic        PD_OE;
    logic        INCNO;
    logic [1:0]  BO;
    logic        BUSY;

    fifo_scsi_reader dut (
        .SCLK      (SCLK),
        .RST_FIFO_ (RST_FIFO_),
        .OD        (OD),
        .FIFOEMPTY (FIFOEMPTY),
        .DIRECTION (DIRECTION),
        .LOAD_BO   (LOAD_BO),
        .START_BO  (START_BO),
        .DREQ_     (DREQ_),
        .DACK_     (DACK_),
        .WE_       (WE_),
        .PD        (PD),
        .PD_OE     (PD_OE),
        .INCNO     (INCNO),
        .BO        (BO),
        .BUSY      (BUSY)
    );

    initial SCLK = 1'b0;
    always #5 SCLK = ~SCLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        load;
        logic [1:0]  sbo;
        logic        dir;
        logic        empty;
        logic [31:0] od;
        logic        go;
        logic [7:0]  pd;
        int          incno;
        logic [1:0]  bo;
    } vec_t;

    vec_t       tbl [9];
    logic [7:0] exp_q [$];
    int         vectors    = 0;
    int         miscompares = 0;
    int         cyc        = 0;
    int         incno_seen = 0;
    int         incno_cyc  = -1;
    int         we_low     = 0;
    logic       we_prev    = 1'b1;
    logic       incno_prev = 1'b0;
    logic [7:0] held_pd    = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: sample 1 ns after the rising edge and run the strobe monitor.
    task automatic tick();
        logic [7:0] e;
        @(posedge SCLK);
        #1;
        cyc++;
        if (INCNO) begin
            incno_seen++;
            incno_cyc = cyc;
        end
        chk("incno_not_consecutive", {31'b0, incno_prev & INCNO}, 32'd0);
        chk("pd_oe_vs_dack", {31'b0, PD_OE}, {31'b0, ~DACK_});
        if (we_prev && !WE_) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_strobe: got PD %0h expected no strobe (cycle %0d)", PD, cyc);
                held_pd = PD;
            end else begin
                e = exp_q.pop_front();
                chk("pd_at_strobe", {24'b0, PD}, {24'b0, e});
                held_pd = e;
            end
        end
        if (!WE_) begin
            we_low++;
            chk("dack_during_we", {31'b0, DACK_}, 32'd0);
        end
        if (!we_prev && WE_) begin
            chk("we_low_width", we_low, 32'd2);
            chk("pd_held_after_strobe", {24'b0, PD}, {24'b0, held_pd});
            we_low = 0;
        end
        we_prev    = WE_;
        incno_prev = INCNO;
    endtask

    task automatic clear_monitor();
        we_prev    = 1'b1;
        we_low     = 0;
        incno_prev = 1'b0;
    endtask

    task automatic chk_idle_outputs(input string name);
        chk({name, "_dack"},  {31'b0, DACK_}, 32'd1);
        chk({name, "_we"},    {31'b0, WE_},   32'd1);
        chk({name, "_pd_oe"}, {31'b0, PD_OE}, 32'd0);
        chk({name, "_busy"},  {31'b0, BUSY},  32'd0);
        chk({name, "_incno"}, {31'b0, INCNO}, 32'd0);
    endtask

    initial begin
        int start_cyc;
        int inc0;
        int busy_cnt;

        tbl[0] = '{1'b1, 2'd1, 1'b1, 1'b0, 32'hAABBCCDD, 1'b1, 8'hBB, 0, 2'd0};
        tbl[1] = '{1'b0, 2'd0, 1'b1, 1'b0, 32'hAABBCCDD, 1'b1, 8'hAA, 1, 2'd3};
        tbl[2] = '{1'b0, 2'd0, 1'b0, 1'b0, 32'h11111111, 1'b0, 8'h00, 0, 2'd3};
        tbl[3] = '{1'b0, 2'd0, 1'b1, 1'b1, 32'h22222222, 1'b0, 8'h00, 0, 2'd3};
        tbl[4] = '{1'b1, 2'd2, 1'b1, 1'b0, 32'h12345678, 1'b1, 8'h56, 0, 2'd1};
        tbl[5] = '{1'b0, 2'd0, 1'b1, 1'b0, 32'h12345678, 1'b1, 8'h34, 0, 2'd0};
        tbl[6] = '{1'b1, 2'd0, 1'b1, 1'b0, 32'hCAFEF00D, 1'b1, 8'hCA, 1, 2'd3};
        tbl[7] = '{1'b1, 2'd3, 1'b1, 1'b0, 32'h0F1E2D3C, 1'b1, 8'h3C, 0, 2'd2};
        tbl[8] = '{1'b1, 2'd3, 1'b0, 1'b0, 32'h0F1E2D3C, 1'b0, 8'h00, 0, 2'd3};

        RST_FIFO_ = 1'b0;
        OD        = 32'h0;
        FIFOEMPTY = 1'b1;
        DIRECTION = 1'b0;
        LOAD_BO   = 1'b0;
        START_BO  = 2'd0;
        DREQ_     = 1'b1;

        // Reset values.
        tick();
        tick();
        chk_idle_outputs("reset");
        chk("reset_pd", {24'b0, PD}, 32'h00);
        chk("reset_bo", {30'b0, BO}, 32'd3);
        @(negedge SCLK);
        RST_FIFO_ = 1'b1;
        tick();

        // Four bytes of one longword with DREQ_ held low.
        OD        = 32'h44332211;
        DIRECTION = 1'b1;
        FIFOEMPTY = 1'b0;
        DREQ_     = 1'b0;
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        exp_q.push_back(8'h33);
        exp_q.push_back(8'h44);
        start_cyc = cyc;
        inc0 = incno_seen;
        for (int i = 0; i < 24; i++) tick();
        DREQ_ = 1'b1;
        chk("burst_incno_count", incno_seen - inc0, 32'd1);
        chk("burst_incno_cycle", incno_cyc - start_cyc, 32'd23);
        chk("burst_bo_end", {30'b0, BO}, 32'd3);
        chk("burst_busy_end", {31'b0, BUSY}, 32'd0);
        chk("burst_all_bytes", exp_q.size(), 32'd0);

        // Transaction table: optional pointer load, then a one-cycle DREQ_ pulse.
        for (int v = 0; v < 9; v++) begin
            OD        = tbl[v].od;
            DIRECTION = tbl[v].dir;
            FIFOEMPTY = tbl[v].empty;
            DREQ_     = 1'b0;
            if (tbl[v].load) begin
                LOAD_BO  = 1'b1;
                START_BO = tbl[v].sbo;
                tick();
                LOAD_BO  = 1'b0;
                chk($sformatf("tbl%0d_load_priority", v), {31'b0, BUSY}, 32'd0);
                chk($sformatf("tbl%0d_load_bo", v), {30'b0, BO}, {30'b0, tbl[v].sbo});
            end
            if (tbl[v].go) exp_q.push_back(tbl[v].pd);
            inc0 = incno_seen;
            tick();
            DREQ_ = 1'b1;
            chk($sformatf("tbl%0d_start", v), {31'b0, BUSY}, {31'b0, tbl[v].go});
            busy_cnt = 0;
            for (int i = 0; i < 5; i++) begin
                tick();
                if (BUSY) busy_cnt++;
            end
            if (!tbl[v].go) chk($sformatf("tbl%0d_no_activity", v), busy_cnt, 32'd0);
            chk($sformatf("tbl%0d_incno", v), incno_seen - inc0, tbl[v].incno);
            chk($sformatf("tbl%0d_bo", v), {30'b0, BO}, {30'b0, tbl[v].bo});
            chk($sformatf("tbl%0d_idle", v), {31'b0, BUSY}, 32'd0);
        end

        // FIFO empty with DREQ_ asserted: nothing happens.
        DIRECTION = 1'b1;
        FIFOEMPTY = 1'b1;
        DREQ_     = 1'b0;
        busy_cnt  = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (BUSY || !DACK_ || !WE_ || PD_OE) busy_cnt++;
        end
        chk("empty_no_activity", busy_cnt, 32'd0);
        DREQ_     = 1'b1;
        FIFOEMPTY = 1'b0;
        tick();

        // LOAD_BO during a sequence is ignored.
        OD    = 32'h01020304;
        exp_q.push_back(8'h04);
        DREQ_ = 1'b0;
        tick();
        DREQ_ = 1'b1;
        tick();
        LOAD_BO  = 1'b1;
        START_BO = 2'd0;
        tick();
        tick();
        LOAD_BO = 1'b0;
        tick();
        tick();
        chk("load_ignored_bo", {30'b0, BO}, 32'd2);

        // DIRECTION falls mid-byte: byte completes, then no new start.
        exp_q.push_back(8'h03);
        DREQ_ = 1'b0;
        tick();
        DIRECTION = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("dir_fall_bo", {30'b0, BO}, 32'd1);
        chk("dir_fall_byte_done", exp_q.size(), 32'd0);
        busy_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (BUSY) busy_cnt++;
        end
        chk("dir_low_no_start", busy_cnt, 32'd0);
        DREQ_     = 1'b1;
        DIRECTION = 1'b1;

        // Reset during STROBE1 of the BO=0 byte.
        LOAD_BO  = 1'b1;
        START_BO = 2'd0;
        tick();
        LOAD_BO = 1'b0;
        OD      = 32'h99887766;
        exp_q.push_back(8'h99);
        DREQ_   = 1'b0;
        tick();
        tick();
        chk("rst_mid_in_strobe1", {31'b0, WE_}, 32'd0);
        inc0 = incno_seen;
        #2;
        RST_FIFO_ = 1'b0;
        #1;
        chk_idle_outputs("async_reset");
        chk("async_reset_bo", {30'b0, BO}, 32'd3);
        clear_monitor();
        tick();
        tick();
        chk("rst_hold_busy", {31'b0, BUSY}, 32'd0);
        @(negedge SCLK);
        RST_FIFO_ = 1'b1;
        #1;
        chk("rst_release_no_early_start", {31'b0, BUSY}, 32'd0);
        chk("rst_no_incno", incno_seen - inc0, 32'd0);
        exp_q.push_back(8'h66);
        tick();
        DREQ_ = 1'b1;
        chk("rst_release_start", {31'b0, BUSY}, 32'd1);
        for (int i = 0; i < 5; i++) tick();
        chk("rst_release_bo", {30'b0, BO}, 32'd2);
        chk("scoreboard_drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
